// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding
// and the RISC-V funct3 size/sign codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_if.sv
// Data-memory request/grant/response bus between the LSU (master) and the
// data memory (slave).
interface lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and lane replication,
// access legality decode, and load byte/half extraction with extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic        st_we,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_lanes,
  output logic        st_bad,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Unsigned size codes are only meaningful for loads; stores using them are illegal.
  always_comb begin
    st_be    = 4'b0000;
    st_lanes = st_wdata;
    st_bad   = 1'b0;
    case (st_funct3)
      F3_B, F3_BU: begin
        st_be    = 4'b0001 << st_off;
        st_lanes = {4{st_wdata[7:0]}};
        st_bad   = st_we && (st_funct3 == F3_BU);
      end
      F3_H, F3_HU: begin
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
        st_lanes = {2{st_wdata[15:0]}};
        st_bad   = st_off[0] || (st_we && (st_funct3 == F3_HU));
      end
      F3_W: begin
        st_be  = 4'b1111;
        st_bad = (st_off != 2'b00);
      end
      default: st_bad = 1'b1;
    endcase
  end

  assign ld_byte = ld_word[{ld_off, 3'b000} +: 8];
  assign ld_half = ld_word[{ld_off[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = ld_word;
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'h000000, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'h0000, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: issues one data-memory access per load/store instruction
// and stalls the core until the access completes with a one-cycle done pulse.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  lsu_if.master             mem
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              accept;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_lanes;
  logic              st_bad;
  logic [DATA_W-1:0] ld_data;

  lsu_align u_align (
    .st_funct3 (req_funct3),
    .st_we     (req_we),
    .st_off    (req_addr[1:0]),
    .st_wdata  (req_wdata),
    .st_be     (st_be),
    .st_lanes  (st_lanes),
    .st_bad    (st_bad),
    .ld_funct3 (funct3_q),
    .ld_off    (off_q),
    .ld_word   (mem.mem_rdata),
    .ld_data   (ld_data)
  );

  // The done cycle belongs to the finishing instruction, so it never accepts.
  assign accept = (state_q == IDLE) && req_valid && !done_q;
  assign stall  = req_valid && !done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !st_bad) state_d = REQ;
      REQ:     if (mem.mem_gnt) state_d = we_q ? IDLE : WAIT;
      WAIT:    if (mem.mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && st_bad) begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end else if (accept) begin
          we_d        = req_we;
          funct3_d    = req_funct3;
          off_d       = req_addr[1:0];
          mem_req_d   = 1'b1;
          mem_we_d    = req_we;
          mem_be_d    = st_be;
          mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
          mem_wdata_d = st_lanes;
        end
      end
      REQ: begin
        if (mem.mem_gnt) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          done_d    = we_q;
        end
      end
      WAIT: begin
        if (mem.mem_rvalid) begin
          rdata_d = ld_data;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign done          = done_q;
  assign err           = err_q;
  assign rdata         = rdata_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios followed by randomized
// accesses checked against a byte-level memory and extension model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata = 32'h0;
  bit          done_now = 1'b0;
  logic [31:0] mem_model [64];

  lsu_if mem_bus ();

  lsu dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .mem        (mem_bus.master)
  );

  always #5 clk = ~clk;

  // Access size in bytes, taken straight from the low funct3 bits.
  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit legal(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    bit ok;
    if (we) ok = f3 inside {3'd0, 3'd1, 3'd2};
    else    ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    return ok && ((addr % size_of(f3)) == 0);
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
    int s = size_of(f3);
    return 4'(((1 << s) - 1) << addr[1:0]);
  endfunction

  // Lane i carries store byte (i mod size): replication of the low bytes.
  function automatic logic [31:0] exp_lanes(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int s = size_of(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % s) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
    logic [31:0] v;
    logic [31:0] mask;
    int s = size_of(f3);
    v = word >> (8 * addr[1:0]);
    if (s < 4) begin
      mask = (32'h1 << (8 * s)) - 32'h1;
      v = v & mask;
      if (!f3[2] && v[8*s-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Idle cycles with stray rvalid pulses that the LSU must ignore.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      mem_bus.mem_rvalid = ($urandom_range(0, 3) == 0);
      mem_bus.mem_rdata  = $urandom;
      cycle();
      mem_bus.mem_rvalid = 1'b0;
      checkOutput("idle_no_done", done, 0);
      checkOutput("idle_no_stall", stall, 0);
      checkOutput("idle_rdata_hold", rdata, last_rdata);
    end
    done_now = 1'b0;
  endtask

  // One complete instruction, starting at a negedge, acting as data memory too.
  task automatic applyStimulus(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                               input bit spur);
    bit          ok    = legal(we, f3, addr);
    logic [3:0]  be_e  = exp_be(f3, addr);
    logic [31:0] lanes = exp_lanes(f3, wd);
    logic [31:0] word;
    logic [31:0] exp;
    int          idx   = int'(addr[7:2]);

    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    if (done_now) begin
      cycle();
      checkOutput("done_single_pulse", done, 0);
      checkOutput("stall_new_instr", stall, 1);
    end
    cycle();
    if (!ok) begin
      checkOutput("err_done", done, 1);
      checkOutput("err_flag", err, 1);
      checkOutput("err_no_req", mem_bus.mem_req, 0);
      checkOutput("err_stall_low", stall, 0);
      checkOutput("err_rdata_hold", rdata, last_rdata);
      req_valid = 1'b0;
      done_now  = 1'b1;
      return;
    end
    checkOutput("req_rise", mem_bus.mem_req, 1);
    checkOutput("req_we", mem_bus.mem_we, we);
    checkOutput("req_be", mem_bus.mem_be, be_e);
    checkOutput("req_addr", mem_bus.mem_addr, addr & 32'hFFFF_FFFC);
    if (we) checkOutput("req_wdata", mem_bus.mem_wdata, lanes);
    checkOutput("req_no_done", done, 0);
    checkOutput("req_stall", stall, 1);
    for (int i = 0; i < gnt_dly; i++) begin
      if (spur && i == 0) begin
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 32'hBAD0_BAD0;
      end
      cycle();
      mem_bus.mem_rvalid = 1'b0;
      checkOutput("hold_req", mem_bus.mem_req, 1);
      checkOutput("hold_be", mem_bus.mem_be, be_e);
      checkOutput("hold_addr", mem_bus.mem_addr, addr & 32'hFFFF_FFFC);
      if (we) checkOutput("hold_wdata", mem_bus.mem_wdata, lanes);
      checkOutput("hold_no_done", done, 0);
      checkOutput("hold_stall", stall, 1);
    end
    mem_bus.mem_gnt = 1'b1;
    cycle();
    mem_bus.mem_gnt = 1'b0;
    if (we) begin
      checkOutput("st_done", done, 1);
      checkOutput("st_err", err, 0);
      checkOutput("st_req_drop", mem_bus.mem_req, 0);
      checkOutput("st_stall_low", stall, 0);
      checkOutput("st_rdata_hold", rdata, last_rdata);
      for (int i = 0; i < 4; i++)
        if (be_e[i]) mem_model[idx][8*i +: 8] = lanes[8*i +: 8];
    end else begin
      checkOutput("ld_req_drop", mem_bus.mem_req, 0);
      checkOutput("ld_wait_no_done", done, 0);
      checkOutput("ld_wait_stall", stall, 1);
      for (int i = 0; i < rv_dly; i++) begin
        cycle();
        checkOutput("ld_wait_no_done", done, 0);
        checkOutput("ld_wait_stall", stall, 1);
      end
      word = mem_model[idx];
      mem_bus.mem_rvalid = 1'b1;
      mem_bus.mem_rdata  = word;
      cycle();
      mem_bus.mem_rvalid = 1'b0;
      mem_bus.mem_rdata  = $urandom;
      exp = exp_load(f3, addr, word);
      checkOutput("ld_done", done, 1);
      checkOutput("ld_err", err, 0);
      checkOutput("ld_rdata", rdata, exp);
      checkOutput("ld_stall_low", stall, 0);
      last_rdata = exp;
    end
    req_valid = 1'b0;
    done_now  = 1'b1;
  endtask

  initial begin
    logic [2:0] ld_codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bit          r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;

    reset              = 1'b1;
    req_valid          = 1'b0;
    req_we             = 1'b0;
    req_funct3         = 3'b000;
    req_addr           = 32'h0;
    req_wdata          = 32'h0;
    mem_bus.mem_gnt    = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    mem_bus.mem_rdata  = 32'h0;
    for (int i = 0; i < 64; i++) mem_model[i] = $urandom;

    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_mem_req", mem_bus.mem_req, 0);
    checkOutput("rst_mem_we", mem_bus.mem_we, 0);
    checkOutput("rst_mem_be", mem_bus.mem_be, 0);
    checkOutput("rst_mem_addr", mem_bus.mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_bus.mem_wdata, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_stall", stall, 0);
    reset = 1'b0;
    idle(1);

    // Stores from the plan: SW with a two-cycle grant, then SB on the top lane.
    applyStimulus(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 2, 0, 1'b0);
    idle(1);
    applyStimulus(1'b1, 3'b000, 32'h103, 32'h0000_00A5, 0, 0, 1'b0);
    idle(1);

    mem_model[0] = 32'h1234_8056;
    applyStimulus(1'b0, 3'b000, 32'h101, 32'h0, 0, 0, 1'b0);
    checkOutput("lb_const", rdata, 32'hFFFF_FF80);
    applyStimulus(1'b0, 3'b100, 32'h101, 32'h0, 1, 0, 1'b0);
    checkOutput("lbu_const", rdata, 32'h0000_0080);
    applyStimulus(1'b0, 3'b101, 32'h102, 32'h0, 0, 1, 1'b0);
    checkOutput("lhu_const", rdata, 32'h0000_1234);
    idle(1);

    // Misaligned and illegal-code accesses, some back to back.
    applyStimulus(1'b0, 3'b010, 32'h102, 32'h0, 0, 0, 1'b0);
    applyStimulus(1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 1'b0);
    applyStimulus(1'b0, 3'b001, 32'h101, 32'h0, 0, 0, 1'b0);
    applyStimulus(1'b1, 3'b100, 32'h100, 32'h0, 0, 0, 1'b0);
    idle(1);

    applyStimulus(1'b0, 3'b010, 32'h104, 32'h0, 3, 5, 1'b1);
    idle(1);

    // Reset while the request is still waiting for grant.
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h108;
    cycle();
    checkOutput("rreq_req_up", mem_bus.mem_req, 1);
    #2 reset = 1'b1;
    #1 checkOutput("rreq_req_async_drop", mem_bus.mem_req, 0);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    last_rdata = 32'h0;
    idle(2);

    // Reset while waiting for load data; a later rvalid must not complete anything.
    req_valid = 1'b1;
    req_addr  = 32'h10C;
    cycle();
    mem_bus.mem_gnt = 1'b1;
    cycle();
    mem_bus.mem_gnt = 1'b0;
    checkOutput("rwait_req_low", mem_bus.mem_req, 0);
    #2 reset = 1'b1;
    #1 checkOutput("rwait_req_low_rst", mem_bus.mem_req, 0);
    checkOutput("rwait_no_done_rst", done, 0);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    mem_bus.mem_rvalid = 1'b1;
    mem_bus.mem_rdata  = 32'h5555_AAAA;
    cycle();
    mem_bus.mem_rvalid = 1'b0;
    checkOutput("rwait_no_done", done, 0);
    checkOutput("rwait_rdata_cleared", rdata, 0);
    idle(2);
    applyStimulus(1'b1, 3'b010, 32'h10C, 32'hCAFE_F00D, 0, 0, 1'b0);
    applyStimulus(1'b0, 3'b010, 32'h10C, 32'h0, 1, 0, 1'b0);
    checkOutput("post_reset_lw", rdata, 32'hCAFE_F00D);
    idle(1);

    // Randomized mix of sizes, offsets, latencies and gaps.
    for (int n = 0; n < 200; n++) begin
      r_we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) r_f3 = 3'($urandom_range(0, 7));
      else if (r_we)                 r_f3 = 3'($urandom_range(0, 2));
      else                           r_f3 = ld_codes[$urandom_range(0, 4)];
      r_addr = 32'h100 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0 && size_of(r_f3) <= 4)
        r_addr = r_addr & ~(32'(size_of(r_f3)) - 32'h1);
      applyStimulus(r_we, r_f3, r_addr, $urandom, $urandom_range(0, 3),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
